// File: rtl/weighted_center_of_mass_if.sv
// rtl/weighted_center_of_mass_if.sv - node sample stream and result bus of the centre-of-mass engine
interface weighted_center_of_mass_if #(
    parameter int POS_WIDTH  = 16,
    parameter int MASS_WIDTH = 8,
    parameter int BODY_W     = 2
);
    logic [POS_WIDTH-1:0]  x_in;
    logic [POS_WIDTH-1:0]  y_in;
    logic [MASS_WIDTH-1:0] mass_in;
    logic [BODY_W-1:0]     body_in;
    logic                  valid_in;
    logic                  ready_out;
    logic                  tabulate_in;
    logic [POS_WIDTH-1:0]  x_out;
    logic [POS_WIDTH-1:0]  y_out;
    logic [BODY_W-1:0]     body_out;
    logic                  valid_out;
    logic                  empty_out;
    logic                  overflow_out;

    modport master (
        output x_in, y_in, mass_in, body_in, valid_in, tabulate_in,
        input  ready_out, x_out, y_out, body_out, valid_out, empty_out, overflow_out
    );

    modport slave (
        input  x_in, y_in, mass_in, body_in, valid_in, tabulate_in,
        output ready_out, x_out, y_out, body_out, valid_out, empty_out, overflow_out
    );
endinterface

// File: rtl/weighted_center_of_mass.sv
// rtl/weighted_center_of_mass.sv - mass-weighted multi-body centre-of-mass engine with sequential divider
module weighted_center_of_mass #(
    parameter int POS_WIDTH  = 16,
    parameter int MASS_WIDTH = 8,
    parameter int MAX_NODES  = 64,
    parameter int NUM_BODIES = 4,
    parameter int BODY_W     = (NUM_BODIES > 1) ? $clog2(NUM_BODIES) : 1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    weighted_center_of_mass_if.slave bus
);
    localparam int CNT_W  = $clog2(MAX_NODES + 1);
    localparam int MSUM_W = MASS_WIDTH + CNT_W;
    localparam int ACC_W  = POS_WIDTH + MSUM_W;
    localparam int DCNT_W = $clog2(ACC_W);
    localparam int BW1    = BODY_W + 1;

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_NODES);
    localparam logic [BODY_W-1:0] LAST_BODY = BODY_W'(NUM_BODIES - 1);
    localparam logic [BW1-1:0]    BODY_LIM  = BW1'(NUM_BODIES);
    localparam logic [DCNT_W-1:0] DIV_LAST  = DCNT_W'(ACC_W - 1);

    typedef enum logic [2:0] {
        S_TALLY,
        S_LOAD,
        S_DIV_RUN,
        S_EMIT,
        S_CLEAR
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0]      xs_q  [NUM_BODIES];
    logic [ACC_W-1:0]      ys_q  [NUM_BODIES];
    logic [MSUM_W-1:0]     ms_q  [NUM_BODIES];
    logic [CNT_W-1:0]      cnt_q [NUM_BODIES];
    logic [NUM_BODIES-1:0] ovf_q;

    logic [BODY_W-1:0] ptr_q, ptr_d;

    logic [POS_WIDTH-1:0] x_out_q, x_out_d;
    logic [POS_WIDTH-1:0] y_out_q, y_out_d;
    logic [BODY_W-1:0]    body_out_q, body_out_d;
    logic                 valid_q, valid_d;
    logic                 empty_q, empty_d;
    logic                 ovf_out_q, ovf_out_d;

    logic             body_legal;
    logic             accept;
    logic             room;
    logic [ACC_W-1:0] x_prod;
    logic [ACC_W-1:0] y_prod;

    assign body_legal = ({1'b0, bus.body_in} < BODY_LIM);
    assign accept     = (state_q == S_TALLY) && bus.valid_in && body_legal;
    assign room       = (cnt_q[bus.body_in] < MAX_CNT);
    assign x_prod     = ACC_W'(bus.x_in) * ACC_W'(bus.mass_in);
    assign y_prod     = ACC_W'(bus.y_in) * ACC_W'(bus.mass_in);

    // Per-body accumulators; CLEAR wipes them once the sweep has emitted every body.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int b = 0; b < NUM_BODIES; b++) begin
                xs_q[b]  <= '0;
                ys_q[b]  <= '0;
                ms_q[b]  <= '0;
                cnt_q[b] <= '0;
            end
            ovf_q <= '0;
        end else if (state_q == S_CLEAR) begin
            for (int b = 0; b < NUM_BODIES; b++) begin
                xs_q[b]  <= '0;
                ys_q[b]  <= '0;
                ms_q[b]  <= '0;
                cnt_q[b] <= '0;
            end
            ovf_q <= '0;
        end else if (accept) begin
            if (room) begin
                xs_q[bus.body_in]  <= xs_q[bus.body_in] + x_prod;
                ys_q[bus.body_in]  <= ys_q[bus.body_in] + y_prod;
                ms_q[bus.body_in]  <= ms_q[bus.body_in] + MSUM_W'(bus.mass_in);
                cnt_q[bus.body_in] <= cnt_q[bus.body_in] + CNT_W'(1);
            end else begin
                ovf_q[bus.body_in] <= 1'b1;
            end
        end
    end

    // Two restoring dividers sharing one divisor; the dividend register shifts
    // left and collects quotient bits at its LSB.
    logic [ACC_W-1:0]  xq_q, yq_q, xq_nx, yq_nx;
    logic [MSUM_W-1:0] xr_q, yr_q, xr_nx, yr_nx;
    logic [MSUM_W-1:0] dvs_q;
    logic [MSUM_W:0]   xr_sh, yr_sh, xr_sub, yr_sub;
    logic              x_ge, y_ge;
    logic [DCNT_W-1:0] dcnt_q;
    logic              cur_empty;

    assign cur_empty = (ms_q[ptr_q] == '0);

    always_comb begin
        xr_sh  = {xr_q, xq_q[ACC_W-1]};
        yr_sh  = {yr_q, yq_q[ACC_W-1]};
        xr_sub = xr_sh - {1'b0, dvs_q};
        yr_sub = yr_sh - {1'b0, dvs_q};
        x_ge   = (xr_sh >= {1'b0, dvs_q});
        y_ge   = (yr_sh >= {1'b0, dvs_q});
        xr_nx  = x_ge ? xr_sub[MSUM_W-1:0] : xr_sh[MSUM_W-1:0];
        yr_nx  = y_ge ? yr_sub[MSUM_W-1:0] : yr_sh[MSUM_W-1:0];
        xq_nx  = {xq_q[ACC_W-2:0], x_ge};
        yq_nx  = {yq_q[ACC_W-2:0], y_ge};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            xq_q   <= '0;
            yq_q   <= '0;
            xr_q   <= '0;
            yr_q   <= '0;
            dvs_q  <= '0;
            dcnt_q <= '0;
        end else if (state_q == S_LOAD) begin
            xq_q   <= xs_q[ptr_q];
            yq_q   <= ys_q[ptr_q];
            xr_q   <= '0;
            yr_q   <= '0;
            dvs_q  <= ms_q[ptr_q];
            dcnt_q <= DIV_LAST;
        end else if (state_q == S_DIV_RUN) begin
            xq_q   <= xq_nx;
            yq_q   <= yq_nx;
            xr_q   <= xr_nx;
            yr_q   <= yr_nx;
            dcnt_q <= dcnt_q - DCNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        body_out_d = body_out_q;
        valid_d    = 1'b0;
        empty_d    = 1'b0;
        ovf_out_d  = 1'b0;
        unique case (state_q)
            S_TALLY: begin
                if (bus.tabulate_in) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end
            end
            S_LOAD: begin
                if (cur_empty) begin
                    state_d    = S_EMIT;
                    x_out_d    = '0;
                    y_out_d    = '0;
                    body_out_d = ptr_q;
                    valid_d    = 1'b1;
                    empty_d    = 1'b1;
                    ovf_out_d  = ovf_q[ptr_q];
                end else begin
                    state_d = S_DIV_RUN;
                end
            end
            S_DIV_RUN: begin
                // Result registers load from the final quotient step so the
                // strobe coincides with the EMIT cycle.
                if (dcnt_q == '0) begin
                    state_d    = S_EMIT;
                    x_out_d    = xq_nx[POS_WIDTH-1:0];
                    y_out_d    = yq_nx[POS_WIDTH-1:0];
                    body_out_d = ptr_q;
                    valid_d    = 1'b1;
                    ovf_out_d  = ovf_q[ptr_q];
                end
            end
            S_EMIT: begin
                if (ptr_q == LAST_BODY) begin
                    state_d = S_CLEAR;
                end else begin
                    ptr_d   = ptr_q + BODY_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_CLEAR: state_d = S_TALLY;
            default: state_d = S_TALLY;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_TALLY;
            ptr_q      <= '0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            body_out_q <= '0;
            valid_q    <= 1'b0;
            empty_q    <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            body_out_q <= body_out_d;
            valid_q    <= valid_d;
            empty_q    <= empty_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign bus.ready_out    = (state_q == S_TALLY);
    assign bus.x_out        = x_out_q;
    assign bus.y_out        = y_out_q;
    assign bus.body_out     = body_out_q;
    assign bus.valid_out    = valid_q;
    assign bus.empty_out    = empty_q;
    assign bus.overflow_out = ovf_out_q;
endmodule

// File: tb/tb_weighted_center_of_mass.sv
// tb/tb_weighted_center_of_mass.sv - self-checking bench for weighted_center_of_mass
module tb_weighted_center_of_mass;
    localparam int POS_W  = 16;
    localparam int MASS_W = 8;
    localparam int MAXN   = 64;
    localparam int NB     = 4;
    localparam int BW     = 2;
    localparam int ACC_W  = POS_W + MASS_W + $clog2(MAXN + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    weighted_center_of_mass_if #(.POS_WIDTH(POS_W), .MASS_WIDTH(MASS_W), .BODY_W(BW)) bus ();

    weighted_center_of_mass #(
        .POS_WIDTH(POS_W), .MASS_WIDTH(MASS_W), .MAX_NODES(MAXN), .NUM_BODIES(NB), .BODY_W(BW)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    typedef struct {
        int     cyc;
        int     body;
        longint x;
        longint y;
        bit     empty;
        bit     ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    bit     chk_en  = 1'b0;
    int     busy_lo = 1;
    int     busy_hi = 0;
    longint hold_x  = 0;
    longint hold_y  = 0;
    longint hold_b  = 0;

    longint m_xs[NB];
    longint m_ys[NB];
    longint m_ms[NB];
    int     m_cnt[NB];
    bit     m_ovf[NB];

    longint got_x[NB];
    longint got_y[NB];
    longint got_e[NB];
    longint got_o[NB];
    longint got_cyc[NB];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NB; i++) begin
            m_xs[i] = 0; m_ys[i] = 0; m_ms[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end
    endfunction

    function automatic void model_add(input int b, input longint x, input longint y, input longint m);
        if (b < 0 || b >= NB) return;
        if (m_cnt[b] < MAXN) begin
            m_xs[b] += x * m;
            m_ys[b] += y * m;
            m_ms[b] += m;
            m_cnt[b]++;
        end else begin
            m_ovf[b] = 1'b1;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (chk_en && rst_n) begin
            chk("ready_out", bus.ready_out, (cyc >= busy_lo && cyc <= busy_hi) ? 0 : 1);
            if (bus.valid_out) begin
                chk("strobe_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("body_out", bus.body_out, e.body);
                    chk("x_out", bus.x_out, e.x);
                    chk("y_out", bus.y_out, e.y);
                    chk("empty_out", bus.empty_out, e.empty);
                    chk("overflow_out", bus.overflow_out, e.ovf);
                    hold_x = e.x; hold_y = e.y; hold_b = e.body;
                    got_x[e.body]   = bus.x_out;
                    got_y[e.body]   = bus.y_out;
                    got_e[e.body]   = bus.empty_out;
                    got_o[e.body]   = bus.overflow_out;
                    got_cyc[e.body] = cyc;
                end
            end else begin
                chk("empty_idle", bus.empty_out, 0);
                chk("overflow_idle", bus.overflow_out, 0);
                chk("x_hold", bus.x_out, hold_x);
                chk("y_hold", bus.y_out, hold_y);
                chk("body_hold", bus.body_out, hold_b);
            end
        end
    end

    task automatic step_idle();
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.tabulate_in = 1'b0;
    endtask

    task automatic send(input int b, input longint x, input longint y, input longint m);
        @(posedge clk); #1;
        bus.valid_in    = 1'b1;
        bus.tabulate_in = 1'b0;
        bus.body_in     = BW'(b);
        bus.x_in        = POS_W'(x);
        bus.y_in        = POS_W'(y);
        bus.mass_in     = MASS_W'(m);
        model_add(b, x, y, m);
    endtask

    task automatic tabulate(input bit with_node, input int b, input longint x, input longint y, input longint m);
        int load;
        @(posedge clk); #1;
        bus.tabulate_in = 1'b1;
        bus.valid_in    = with_node;
        bus.body_in     = BW'(b);
        bus.x_in        = POS_W'(x);
        bus.y_in        = POS_W'(y);
        bus.mass_in     = MASS_W'(m);
        if (with_node) model_add(b, x, y, m);
        busy_lo = cyc + 1;
        load = cyc + 1;
        for (int i = 0; i < NB; i++) begin
            exp_t e;
            bit emp;
            emp = (m_ms[i] == 0);
            e.cyc   = load + (emp ? 1 : ACC_W + 1);
            e.body  = i;
            e.x     = emp ? 0 : m_xs[i] / m_ms[i];
            e.y     = emp ? 0 : m_ys[i] / m_ms[i];
            e.empty = emp;
            e.ovf   = m_ovf[i];
            exp_q.push_back(e);
            got_x[i] = -1; got_y[i] = -1; got_e[i] = -1; got_o[i] = -1; got_cyc[i] = -1;
            load = e.cyc + 1;
        end
        busy_hi = load;
        model_clear();
    endtask

    task automatic run_sweep(input bit junk);
        int guard;
        guard = 0;
        while (cyc <= busy_hi && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
            if (junk && cyc <= busy_hi) begin
                bus.valid_in    = 1'($urandom_range(0, 1));
                bus.tabulate_in = ($urandom_range(0, 3) == 0);
                bus.body_in     = BW'($urandom_range(0, NB - 1));
                bus.x_in        = POS_W'($urandom_range(0, 65535));
                bus.y_in        = POS_W'($urandom_range(0, 65535));
                bus.mass_in     = MASS_W'($urandom_range(1, 255));
            end else begin
                bus.valid_in    = 1'b0;
                bus.tabulate_in = 1'b0;
            end
        end
        bus.valid_in    = 1'b0;
        bus.tabulate_in = 1'b0;
        step_idle();
        step_idle();
        chk("sweep_complete", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n, focus, b, m;
        bit conc;
        bus.valid_in = 1'b0; bus.tabulate_in = 1'b0; bus.body_in = '0;
        bus.x_in = '0; bus.y_in = '0; bus.mass_in = '0;
        model_clear();

        #12;
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_x", bus.x_out, 0);
        chk("rst_y", bus.y_out, 0);
        chk("rst_body", bus.body_out, 0);
        chk("rst_empty", bus.empty_out, 0);
        chk("rst_ovf", bus.overflow_out, 0);
        chk("rst_ready", bus.ready_out, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        step_idle();

        // weighted mean
        send(0, 10, 20, 1); send(0, 30, 40, 3);
        tabulate(0, 0, 0, 0, 0); run_sweep(0);
        chk("wm_x0", got_x[0], 25); chk("wm_y0", got_y[0], 35); chk("wm_e0", got_e[0], 0);
        chk("wm_e1", got_e[1], 1); chk("wm_x3", got_x[3], 0); chk("wm_gap01", got_cyc[1] - got_cyc[0], 2);

        // truncation
        send(1, 0, 0, 1); send(1, 1, 1, 1);
        tabulate(0, 0, 0, 0, 0); run_sweep(0);
        chk("tr_x1", got_x[1], 0); chk("tr_y1", got_y[1], 0); chk("tr_e1", got_e[1], 0);

        // ordering and empty skip
        send(2, 500, 600, 7);
        tabulate(0, 0, 0, 0, 0); run_sweep(0);
        chk("ord_x2", got_x[2], 500); chk("ord_y2", got_y[2], 600);
        chk("ord_gap01", got_cyc[1] - got_cyc[0], 2); chk("ord_gap12", got_cyc[2] - got_cyc[1], 33);

        // overflow and its clearing
        for (int i = 0; i < 64; i++) send(3, 100, 100, 1);
        send(3, 1000, 1000, 255);
        tabulate(0, 0, 0, 0, 0); run_sweep(0);
        chk("ovf_x3", got_x[3], 100); chk("ovf_y3", got_y[3], 100); chk("ovf_flag3", got_o[3], 1);
        send(3, 5, 7, 2);
        tabulate(0, 0, 0, 0, 0); run_sweep(0);
        chk("ovf_clr3", got_o[3], 0); chk("ovf_clr_x3", got_x[3], 5); chk("ovf_clr_y3", got_y[3], 7);

        // saturation bound
        for (int i = 0; i < 64; i++) send(0, 65535, 65535, 255);
        tabulate(0, 0, 0, 0, 0); run_sweep(0);
        chk("sat_x0", got_x[0], 65535); chk("sat_y0", got_y[0], 65535);

        // busy drop, tabulate with concurrent node
        send(1, 200, 300, 2);
        tabulate(1, 1, 200, 300, 6); run_sweep(1);
        chk("busy_x1", got_x[1], 200); chk("busy_y1", got_y[1], 300);

        // reset mid-sweep
        send(0, 123, 456, 3);
        tabulate(0, 0, 0, 0, 0);
        repeat (10) step_idle();
        @(posedge clk); #1;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.valid_out, 0);
        chk("abort_x", bus.x_out, 0);
        chk("abort_y", bus.y_out, 0);
        chk("abort_body", bus.body_out, 0);
        chk("abort_ready", bus.ready_out, 1);
        exp_q.delete();
        busy_lo = 1; busy_hi = 0; hold_x = 0; hold_y = 0; hold_b = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (80) step_idle();

        // fresh tally after reset
        send(2, 9, 21, 3); send(2, 3, 1, 1);
        tabulate(0, 0, 0, 0, 0); run_sweep(0);
        chk("fresh_x2", got_x[2], 7); chk("fresh_y2", got_y[2], 16);

        // randomized rounds
        for (int r = 0; r < 25; r++) begin
            n     = $urandom_range(0, 90);
            focus = $urandom_range(0, NB - 1);
            conc  = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < n; k++) begin
                b = conc ? focus : $urandom_range(0, NB - 1);
                m = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 255);
                if ($urandom_range(0, 3) == 0) step_idle();
                send(b, $urandom_range(0, 65535), $urandom_range(0, 65535), m);
            end
            tabulate(1'($urandom_range(0, 1)), $urandom_range(0, NB - 1),
                     $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 255));
            run_sweep(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
